// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: drives the PC register input, runs the imem fetch
// handshake, issues instructions to decode, and halts on fault or request.
// Ports: clk/reset; pc_current -> pc_next; imem_req/addr/ack/rdata;
// inst_valid/out/pc with core_ready; redirect/trap/halt requests;
// halted and sticky fault status.
module pc_fetch_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_1000,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc_current,
  output logic [DATA_WIDTH-1:0] pc_next,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  core_ready,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  trap_req,
  input  logic                  halt_req,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    ISSUE,
    HALT
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(FETCH_TIMEOUT - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [DATA_WIDTH-1:0] ipc_q;
  logic                  fault_q;
  logic                  hs;
  logic                  misaligned;

  assign hs         = (state == ISSUE) && core_ready;
  assign misaligned = |redirect_target[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT;
      cnt     <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          cnt   <= '0;
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            inst_q <= imem_rdata;
            ipc_q  <= pc_current;
            cnt    <= '0;
            state  <= ISSUE;
          end else if (cnt == TO_LAST) begin
            // Memory never answered: give up and freeze the core.
            fault_q <= 1'b1;
            cnt     <= '0;
            state   <= HALT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ISSUE: begin
          if (core_ready) begin
            if (halt_req) begin
              state <= HALT;
            end else if (trap_req) begin
              state <= FETCH;
            end else if (redirect_valid && misaligned) begin
              fault_q <= 1'b1;
              state   <= HALT;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

  always_comb begin
    pc_next = pc_current;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else if (hs) begin
      if (halt_req) begin
        pc_next = pc_current;
      end else if (trap_req) begin
        pc_next = TRAP_VECTOR;
      end else if (redirect_valid) begin
        pc_next = misaligned ? pc_current : redirect_target;
      end else begin
        // Natural wrap at the top of the address space.
        pc_next = pc_current + DATA_WIDTH'(4);
      end
    end
  end

  // Reset gates the visible outputs so they are quiet from the very
  // first reset cycle, before the state register has been cleared.
  assign imem_req   = !reset && (state == FETCH);
  assign imem_addr  = pc_current;
  assign inst_valid = !reset && (state == ISSUE);
  assign halted     = !reset && (state == HALT);
  assign fault      = !reset && fault_q;
  assign inst_out   = reset ? '0 : inst_q;
  assign inst_pc    = reset ? '0 : ipc_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Controller for the single-cycle core's program counter register. The PC register reloads from its input every clock, so this block alone decides when the PC advances, holds, redirects or traps. It drives the PC input, sequences the instruction-memory fetch handshake, presents fetched instructions to the decode stage, and halts the core on fault or request.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction words
RESET_VECTOR, 32'h0000_0000, PC value driven while reset is high
TRAP_VECTOR, 32'h0000_1000, PC target on accepted trap
FETCH_TIMEOUT, 15, max cycles in FETCH without imem_ack before fault (4-bit counter, 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
pc_current  in  DATA_WIDTH  present PC register output
pc_next  out  DATA_WIDTH  value loaded into the PC register next edge
imem_req  out  1  fetch request, combinational from state
imem_addr  out  DATA_WIDTH  fetch address, equals pc_current
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  DATA_WIDTH  instruction word
inst_valid  out  1  instruction available to decode
inst_out  out  DATA_WIDTH  captured instruction
inst_pc  out  DATA_WIDTH  PC of inst_out
core_ready  in  1  decode/execute accepts inst_out this cycle
redirect_valid  in  1  branch/jump taken; qualified by handshake
redirect_target  in  DATA_WIDTH  branch/jump target
trap_req  in  1  exception/ecall; qualified by handshake
halt_req  in  1  stop fetching
halted  out  1  block in HALT
fault  out  1  sticky: misaligned target or fetch timeout

Behaviour:
- States: BOOT, FETCH, ISSUE, HALT; reset forces BOOT.
- While reset high: pc_next=RESET_VECTOR; imem_req=0, inst_valid=0, halted=0, fault=0, inst_out=0, inst_pc=0, timeout counter=0.
- BOOT: one cycle, pc_next=pc_current, then FETCH.
- FETCH: imem_req=1, imem_addr=pc_current, pc_next=pc_current. imem_ack in the same cycle latches imem_rdata->inst_out and pc_current->inst_pc, clears the counter, goes to ISSUE. No ack: counter+1. If the counter reaches FETCH_TIMEOUT without ack, set fault and go to HALT.
- ISSUE: inst_valid=1; inst_out/inst_pc stable. Handshake = inst_valid & core_ready.
  - No handshake: pc_next=pc_current; stay in ISSUE.
  - Handshake: priority halt_req > trap_req > redirect_valid > sequential.
  - halt_req: pc_next=pc_current; go to HALT.
  - trap_req: pc_next=TRAP_VECTOR; go to FETCH.
  - redirect_valid: if redirect_target[1:0]!=0, set fault, pc_next=pc_current, go to HALT. Otherwise pc_next=redirect_target; go to FETCH.
  - Otherwise: pc_next=pc_current+4, modulo 2^DATA_WIDTH; FFFF_FFFC wraps to 0000_0000 without fault.
- redirect_valid, trap_req and halt_req are ignored outside the ISSUE handshake cycle.
- halt_req in FETCH takes effect only after the fetch completes and the instruction is issued.
- HALT: halted=1; pc_next=pc_current; imem_req=0; inst_valid=0. Exits only on reset.
- fault remains set until reset.
- Minimum loop: 2 cycles per instruction (FETCH with immediate ack, ISSUE with core_ready).
- Reset mid-fetch: request abandoned. imem_ack arriving in BOOT is ignored. Next FETCH uses RESET_VECTOR.
- inst_out and inst_pc update only on the FETCH ack cycle.

Test Plan:
- Reset released, imem_ack tied 1, core_ready 1 -> imem_addr sequence 0,4,8,C; inst_pc matches; one instruction per 2 cycles.
- In ISSUE at PC=0x10, redirect_valid=1, target 0x40, handshake -> next FETCH addr 0x40. With core_ready=0, redirect ignored and PC holds 0x10.
- Handshake with trap_req=1 and redirect_valid=1 (target 0x80) together -> next addr 0x1000 (trap wins).
- Redirect target 0x42 at handshake -> fault=1, halted=1 next cycle, imem_req=0, PC frozen. Reset clears both.
- imem_ack held 0 for 15 cycles in FETCH -> fault and halted assert; ack on cycle 14 instead -> normal ISSUE, no fault.
- pc_current=FFFF_FFFC, sequential handshake -> pc_next=0000_0000. Reset asserted during FETCH with ack the same cycle -> pc_next=0, inst_valid stays 0.
